// File: rtl/conv_enc.sv
// Rate-1/2 K=4 convolutional encoder with zero-tail frame termination.
// Optional rate-2/3 puncturing mask on data symbols: CONV_ENC_PUNCT_EN.
module conv_enc #(
    parameter int             K  = 4,
    parameter logic [K-1:0]   G0 = 4'b1111,
    parameter logic [K-1:0]   G1 = 4'b1101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] m_data,
    output logic [1:0] m_keep,
    output logic       m_last
);

    localparam int             CW       = $clog2(K);
    localparam logic [CW-1:0]  TAIL_LEN = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } state_t;

    state_t        state, state_n;
    logic [K-2:0]  sr, sr_n;
    logic [CW-1:0] tail_cnt, cnt_n;
    logic          vld_n;
    logic [1:0]    data_n;
    logic          last_n;

    logic          out_free;
    logic          acc;
    logic          load;
    logic          enc_b;
    logic [K-1:0]  v;
    logic          c0, c1;

    assign out_free = !m_valid || m_ready;
    assign s_ready  = (state != TAIL) && out_free;
    assign acc      = s_valid && s_ready;

    // tail bits are forced to zero so the trellis ends in state 0
    assign enc_b = (state == TAIL) ? 1'b0 : s_data;
    assign v     = {enc_b, sr};
    assign c0    = ^(v & G0);
    assign c1    = ^(v & G1);

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = tail_cnt;
        load    = 1'b0;
        unique case (state)
            IDLE, DATA: begin
                if (acc) begin
                    load    = 1'b1;
                    state_n = s_last ? TAIL : DATA;
                    if (s_last) cnt_n = TAIL_LEN;
                end
            end
            TAIL: begin
                if (out_free) begin
                    load  = 1'b1;
                    cnt_n = tail_cnt - 1'b1;
                    if (tail_cnt == 1) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) sr_n = {enc_b, sr[K-2:1]};
        if (load && state == TAIL && tail_cnt == 1) sr_n = '0;
    end

    always_comb begin
        vld_n  = m_valid && !m_ready;
        data_n = m_data;
        last_n = m_last;
        if (load) begin
            vld_n  = 1'b1;
            data_n = {c1, c0};
            last_n = (state == TAIL) && (tail_cnt == 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sr       <= '0;
            tail_cnt <= '0;
            m_valid  <= 1'b0;
            m_data   <= 2'b00;
            m_last   <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            tail_cnt <= cnt_n;
            m_valid  <= vld_n;
            m_data   <= data_n;
            m_last   <= last_n;
        end
    end

`ifdef CONV_ENC_PUNCT_EN
    logic       phase, phase_n;
    logic [1:0] keep_q, keep_n;

    // first data symbol of a frame is always phase 0
    always_comb begin
        phase_n = phase;
        keep_n  = keep_q;
        if (load) begin
            if (state == TAIL) begin
                keep_n = 2'b11;
            end else begin
                keep_n  = (state != IDLE && phase) ? 2'b01 : 2'b11;
                phase_n = (state == IDLE) ? 1'b1 : ~phase;
            end
        end else if (state == IDLE) begin
            phase_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase  <= 1'b0;
            keep_q <= 2'b11;
        end else begin
            phase  <= phase_n;
            keep_q <= keep_n;
        end
    end

    assign m_keep = keep_q;
`else
    assign m_keep = 2'b11;
`endif

endmodule

// File: tb/tb_conv_enc.sv
// Directed bench for conv_enc: impulse, 3-bit frame, backpressure,
// back-to-back frames, mid-frame reset, optional puncturing mask.
module tb_conv_enc;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic       s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] m_data;
    logic [1:0] m_keep;
    logic       m_last;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef CONV_ENC_PUNCT_EN
    localparam logic [1:0] KP = 2'b01;
`else
    localparam logic [1:0] KP = 2'b11;
`endif

    conv_enc dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got,
                       input logic [1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // wait one clock and check the symbol sitting on the output
    task automatic sym(input string tag, input logic [1:0] d,
                       input logic [1:0] k, input logic l);
        @(negedge clk);
        chk({tag, ".valid"}, {1'b0, m_valid}, 2'b01);
        chk({tag, ".data"}, m_data, d);
        chk({tag, ".keep"}, m_keep, k);
        chk({tag, ".last"}, {1'b0, m_last}, {1'b0, l});
    endtask

    task automatic rdy(input string tag, input logic e);
        chk(tag, {1'b0, s_ready}, {1'b0, e});
    endtask

    initial begin
        rst = 1'b0;
        s_valid = 1'b0;
        s_data = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rdy("rst.s_ready", 1'b1);
        chk("rst.m_valid", {1'b0, m_valid}, 2'b00);
        chk("rst.m_data", m_data, 2'b00);
        chk("rst.m_keep", m_keep, 2'b11);
        chk("rst.m_last", {1'b0, m_last}, 2'b00);

        // impulse frame
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b1;
        sym("imp0", 2'b11, 2'b11, 1'b0);
        s_valid = 1'b0; s_last = 1'b0;
        rdy("imp0.s_ready", 1'b0);
        sym("imp1", 2'b11, 2'b11, 1'b0);
        rdy("imp1.s_ready", 1'b0);
        sym("imp2", 2'b01, 2'b11, 1'b0);
        rdy("imp2.s_ready", 1'b0);
        sym("imp3", 2'b11, 2'b11, 1'b1);
        rdy("imp3.s_ready", 1'b1);
        @(negedge clk);
        chk("imp.idle_valid", {1'b0, m_valid}, 2'b00);

        // frame 1,1,1
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b0;
        sym("f0", 2'b11, 2'b11, 1'b0);
        sym("f1", 2'b00, KP, 1'b0);
        s_last = 1'b1;
        sym("f2", 2'b01, 2'b11, 1'b0);
        s_valid = 1'b0; s_last = 1'b0;
        rdy("f2.s_ready", 1'b0);
        sym("f3", 2'b01, 2'b11, 1'b0);
        sym("f4", 2'b10, 2'b11, 1'b0);
        sym("f5", 2'b11, 2'b11, 1'b1);
        @(negedge clk);
        chk("f.idle_valid", {1'b0, m_valid}, 2'b00);

        // same frame with a 5-cycle stall after the second symbol
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b0;
        sym("b0", 2'b11, 2'b11, 1'b0);
        sym("b1", 2'b00, KP, 1'b0);
        m_ready = 1'b0;
        s_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.valid", {1'b0, m_valid}, 2'b01);
            chk("bp.data", m_data, 2'b00);
            chk("bp.keep", m_keep, KP);
            rdy("bp.s_ready", 1'b0);
        end
        m_ready = 1'b1;
        sym("b2", 2'b01, 2'b11, 1'b0);
        s_valid = 1'b0; s_last = 1'b0;
        sym("b3", 2'b01, 2'b11, 1'b0);
        sym("b4", 2'b10, 2'b11, 1'b0);
        sym("b5", 2'b11, 2'b11, 1'b1);
        @(negedge clk);

        // two impulse frames with s_valid held high
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b1;
        sym("bb0", 2'b11, 2'b11, 1'b0);
        sym("bb1", 2'b11, 2'b11, 1'b0);
        sym("bb2", 2'b01, 2'b11, 1'b0);
        sym("bb3", 2'b11, 2'b11, 1'b1);
        rdy("bb3.s_ready", 1'b1);
        sym("bb4", 2'b11, 2'b11, 1'b0);
        sym("bb5", 2'b11, 2'b11, 1'b0);
        sym("bb6", 2'b01, 2'b11, 1'b0);
        sym("bb7", 2'b11, 2'b11, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("bb.idle_valid", {1'b0, m_valid}, 2'b00);

        // reset after two bits of a frame
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b0;
        sym("r0", 2'b11, 2'b11, 1'b0);
        sym("r1", 2'b00, KP, 1'b0);
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rmid.m_valid", {1'b0, m_valid}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rpost.m_valid", {1'b0, m_valid}, 2'b00);
        rdy("rpost.s_ready", 1'b1);
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b1;
        sym("ri0", 2'b11, 2'b11, 1'b0);
        s_valid = 1'b0; s_last = 1'b0;
        sym("ri1", 2'b11, 2'b11, 1'b0);
        sym("ri2", 2'b01, 2'b11, 1'b0);
        sym("ri3", 2'b11, 2'b11, 1'b1);
        @(negedge clk);

`ifdef CONV_ENC_PUNCT_EN
        // all-zero 4-bit frame: keep pattern 11,01,11,01 then tail 11
        s_valid = 1'b1; s_data = 1'b0; s_last = 1'b0;
        sym("p0", 2'b00, 2'b11, 1'b0);
        sym("p1", 2'b00, 2'b01, 1'b0);
        sym("p2", 2'b00, 2'b11, 1'b0);
        s_last = 1'b1;
        sym("p3", 2'b00, 2'b01, 1'b0);
        s_valid = 1'b0; s_last = 1'b0;
        sym("p4", 2'b00, 2'b11, 1'b0);
        sym("p5", 2'b00, 2'b11, 1'b0);
        sym("p6", 2'b00, 2'b11, 1'b1);
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_enc.md
Name: conv_enc

Overview:
- Rate-1/2 convolutional encoder; the transmit-side counterpart of the Viterbi decoder's traceback unit.
- Accepts a framed serial bit stream through a valid/ready handshake and emits one 2-bit code symbol per input bit.
- Flushes K-1 zero tail bits at the end of each frame, so the decoder trellis terminates in state 0.
- Sits between the frame source and the channel/BMU model.

Parameters:
- K, 4, constraint length; encoder state width is K-1 (3 bits = 8 trellis states, matching the decoder).
- G0, 4'b1111, generator polynomial for code bit c0 (octal 17).
- G1, 4'b1101, generator polynomial for code bit c1 (octal 15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- s_valid  in  1  input bit valid
- s_ready  out  1  encoder can accept an input bit
- s_data  in  1  input information bit
- s_last  in  1  marks the final information bit of a frame
- m_valid  out  1  code symbol valid
- m_ready  in  1  downstream accepts the symbol
- m_data  out  2  code symbol; [0]=c0, [1]=c1
- m_keep  out  2  per-bit transmit mask (puncturing; see Optional Feature)
- m_last  out  1  marks the final symbol of the frame, i.e. the last tail symbol

Behaviour:
- Clock and reset: reset rst, asynchronous, active-low; clock clk; all flops on posedge clk.
- Reset values: state=IDLE, sr=0, tail_cnt=0, m_valid=0, m_data=0, m_keep=2'b11, m_last=0. s_ready is combinational and reads 1 after reset.
- Shift register sr[K-2:0]: sr[K-2] is the most recent past bit, sr[0] the oldest.
- Per encoded bit b:
  - v = {b, sr}
  - c0 = ^(v & G0), c1 = ^(v & G1)
  - next sr = {b, sr[K-2:1]}
- Output register: one stage. A symbol loads when the output is free, i.e. (!m_valid || m_ready). Latency is 1 cycle from input acceptance to m_valid.
- Holding under backpressure: while m_valid && !m_ready, m_data, m_keep and m_last hold stable and no state advances.
- s_ready = (state != TAIL) && (!m_valid || m_ready).
- State machine:
  - IDLE: sr=0. On s_valid && s_ready, encode s_data and go to DATA. If s_last is also set, go directly to TAIL instead.
  - DATA: on each accepted bit, encode it. If s_last, load tail_cnt=K-1 and go to TAIL.
  - TAIL: s_ready=0. Whenever the output is free, encode b=0 and decrement tail_cnt. The symbol emitted with tail_cnt==1 carries m_last=1. Then clear sr and go to IDLE. Exactly K-1 tail symbols are emitted per frame.
- Frame boundaries:
  - A one-bit frame (s_last on the first bit) is legal and yields K symbols.
  - Back-to-back frames: a new frame's first bit is accepted on the cycle after the last tail symbol is loaded. sr is guaranteed zero at that point.
- Ignored inputs: s_data and s_last are ignored unless s_valid && s_ready.
- Reset mid-frame: immediate return to reset values. A pending symbol is dropped and the partial frame is discarded (no tail is emitted).
- Symbol count: a frame of N bits produces N+K-1 symbols; no gaps are inserted when m_ready stays high.

Optional Feature:
- Macro: CONV_ENC_PUNCT_EN.
- Defined: rate-2/3 puncturing on data symbols.
  - A phase flop, cleared in IDLE, toggles on each data symbol emitted.
  - Phase 0 gives m_keep=2'b11; phase 1 gives m_keep=2'b01 (c1 dropped).
  - Tail symbols always carry m_keep=2'b11.
  - m_data is unchanged; the downstream serializer honours m_keep.
- Undefined: m_keep is tied to 2'b11 and there is no phase flop.

Test Plan:
- Impulse frame: s_data=1, s_last=1, m_ready=1 -> 4 symbols (c0,c1) = (1,1),(1,1),(1,0),(1,1); m_last=1 only on the 4th; s_ready=0 for the 3 tail cycles.
- Frame 1,1,1 with s_last on the 3rd bit -> (1,1),(0,0),(1,0) then tail (1,0),(0,1),(1,1) with m_last on the 6th.
- Backpressure: hold m_ready=0 for 5 cycles mid-frame -> m_data stable, s_ready=0, no symbol lost or duplicated; the sequence is identical to the m_ready=1 run.
- Back-to-back: two impulse frames, s_valid held high -> 8 symbols, the second group identical to the first (sr cleared), 2 m_last pulses.
- Reset mid-frame: assert rst low after 2 bits of a frame -> m_valid=0 within the same cycle; the following impulse frame gives the exact impulse response.
- With CONV_ENC_PUNCT_EN: 4-bit all-zero frame -> m_keep sequence 11,01,11,01 then 11,11,11 for the tail; m_data all 0.
